// File: rtl/axi_stream_header_edit.sv
// Per-packet AXI-Stream header prepend / leading-byte strip with a queued command FIFO.
// Output bytes are repacked MSB-first into full beats; only the final beat of a packet may be partial.
module axi_stream_header_edit #(
  parameter int DATA_WD        = 32,
  parameter int DATA_BYTE_WD   = DATA_WD / 8,
  parameter int BYTE_CNT_WD    = $clog2(DATA_BYTE_WD),
  parameter int HDR_FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_in,
  input  logic [DATA_WD-1:0]                data_in,
  input  logic [DATA_BYTE_WD-1:0]           keep_in,
  input  logic                              last_in,
  output logic                              ready_in,
  input  logic                              valid_insert,
  input  logic [DATA_WD-1:0]                data_insert,
  input  logic [DATA_BYTE_WD-1:0]           keep_insert,
  input  logic                              strip_insert,
  input  logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
  output logic                              ready_insert,
  output logic                              valid_out,
  output logic [DATA_WD-1:0]                data_out,
  output logic [DATA_BYTE_WD-1:0]           keep_out,
  output logic                              last_out,
  input  logic                              ready_out,
  output logic                              pkt_drop,
  output logic [$clog2(HDR_FIFO_DEPTH):0]   hdr_level,
  output logic [1:0]                        state_dbg
);

  // Handshake: every channel transfers exactly on a cycle where valid && ready at the rising
  // clock edge; a source holds its payload stable while valid && !ready.

  localparam int PTR_WD = $clog2(HDR_FIFO_DEPTH);
  localparam int LVL_WD = $clog2(HDR_FIFO_DEPTH) + 1;
  localparam int CNT_WD = $clog2(DATA_BYTE_WD) + 2;

  typedef enum logic [1:0] {IDLE, BODY, FLUSH, DROP} state_t;

  state_t                    state;
  logic [2*DATA_WD-1:0]      res;
  logic [CNT_WD-1:0]         rcnt;
  logic                      first_beat;
  logic                      cur_strip;
  logic [BYTE_CNT_WD-1:0]    cur_s;

  logic [DATA_WD-1:0]        fifo_data  [HDR_FIFO_DEPTH];
  logic [DATA_BYTE_WD-1:0]   fifo_keep  [HDR_FIFO_DEPTH];
  logic                      fifo_strip [HDR_FIFO_DEPTH];
  logic [BYTE_CNT_WD-1:0]    fifo_cnt   [HDR_FIFO_DEPTH];
  logic [PTR_WD-1:0]         wr_ptr, rd_ptr;

  function automatic logic [CNT_WD-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [CNT_WD-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_WD'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_WD-1:0] expand(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] e;
    for (int i = 0; i < DATA_BYTE_WD; i++) e[8*i +: 8] = {8{k[i]}};
    return e;
  endfunction

  // Byte i is the (DATA_BYTE_WD-1-i)-th byte on the wire, so it belongs to the top n bytes
  // exactly when DATA_BYTE_WD-i <= n.
  function automatic logic [DATA_BYTE_WD-1:0] top_keep(input logic [CNT_WD-1:0] n);
    logic [DATA_BYTE_WD-1:0] k;
    for (int i = 0; i < DATA_BYTE_WD; i++) k[i] = (CNT_WD'(DATA_BYTE_WD - i) <= n);
    return k;
  endfunction

  logic                      out_free;
  logic                      in_fire;
  logic                      push;
  logic                      pop;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [CNT_WD-1:0]         head_h;
  logic [CNT_WD-1:0]         hdr_pad;
  logic                      head_full;
  logic [DATA_WD-1:0]        head_data;
  logic [DATA_WD-1:0]        head_top;
  logic [CNT_WD-1:0]         in_cnt;
  logic [CNT_WD-1:0]         in_used;
  logic [CNT_WD-1:0]         total;
  logic [DATA_WD-1:0]        in_data;
  logic [2*DATA_WD-1:0]      merged;
  logic                      drop_pkt;

  assign out_free     = !valid_out || ready_out;
  assign ready_in     = (state == BODY) && out_free;
  assign in_fire      = valid_in && ready_in;
  assign fifo_empty   = (hdr_level == '0);
  assign fifo_full    = (hdr_level == LVL_WD'(HDR_FIFO_DEPTH));
  assign pop          = in_fire && first_beat;
  assign ready_insert = !fifo_full || pop;
  assign push         = valid_insert && ready_insert;
  assign state_dbg    = state;

  always_comb begin
    head_data = fifo_data[rd_ptr] & expand(fifo_keep[rd_ptr]);
    head_h    = popcnt(fifo_keep[rd_ptr]);
    head_full = (head_h == CNT_WD'(DATA_BYTE_WD));
    hdr_pad   = CNT_WD'(DATA_BYTE_WD) - head_h;
    head_top  = head_data << {hdr_pad, 3'b000};
  end

  // Unkept input bytes are zeroed so the residual never carries stale bytes past its count.
  always_comb begin
    in_data  = data_in & expand(keep_in);
    in_cnt   = popcnt(keep_in);
    in_used  = in_cnt;
    drop_pkt = 1'b0;
    if (first_beat && cur_strip) begin
      in_data  = in_data << {cur_s, 3'b000};
      drop_pkt = last_in && (in_cnt <= CNT_WD'(cur_s));
      in_used  = drop_pkt ? '0 : in_cnt - CNT_WD'(cur_s);
    end
    merged = res | ({in_data, {DATA_WD{1'b0}}} >> {rcnt, 3'b000});
    total  = rcnt + in_used;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr]  <= data_insert;
      fifo_keep[wr_ptr]  <= keep_insert;
      fifo_strip[wr_ptr] <= strip_insert;
      fifo_cnt[wr_ptr]   <= byte_insert_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hdr_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WD'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WD'(1);
      if (push && !pop)      hdr_level <= hdr_level + LVL_WD'(1);
      else if (pop && !push) hdr_level <= hdr_level - LVL_WD'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      res        <= '0;
      rcnt       <= '0;
      first_beat <= 1'b0;
      cur_strip  <= 1'b0;
      cur_s      <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      keep_out   <= '0;
      last_out   <= 1'b0;
      pkt_drop   <= 1'b0;
    end else begin
      pkt_drop <= 1'b0;
      if (out_free) valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty && out_free) begin
            first_beat <= 1'b1;
            cur_strip  <= fifo_strip[rd_ptr];
            cur_s      <= fifo_cnt[rd_ptr];
            state      <= BODY;
            if (fifo_strip[rd_ptr]) begin
              res  <= '0;
              rcnt <= '0;
            end else if (head_full) begin
              valid_out <= 1'b1;
              data_out  <= head_data;
              keep_out  <= '1;
              last_out  <= 1'b0;
              res       <= '0;
              rcnt      <= '0;
            end else begin
              res  <= {head_top, {DATA_WD{1'b0}}};
              rcnt <= head_h;
            end
          end
        end
        BODY: begin
          if (in_fire) begin
            first_beat <= 1'b0;
            if (drop_pkt) begin
              pkt_drop <= 1'b1;
              res      <= '0;
              rcnt     <= '0;
              state    <= DROP;
            end else if (last_in && total <= CNT_WD'(DATA_BYTE_WD)) begin
              valid_out <= 1'b1;
              data_out  <= merged[2*DATA_WD-1 -: DATA_WD];
              keep_out  <= top_keep(total);
              last_out  <= 1'b1;
              res       <= '0;
              rcnt      <= '0;
              state     <= IDLE;
            end else if (total >= CNT_WD'(DATA_BYTE_WD)) begin
              valid_out <= 1'b1;
              data_out  <= merged[2*DATA_WD-1 -: DATA_WD];
              keep_out  <= '1;
              last_out  <= 1'b0;
              res       <= merged << DATA_WD;
              rcnt      <= total - CNT_WD'(DATA_BYTE_WD);
              if (last_in) state <= FLUSH;
            end else begin
              res  <= merged;
              rcnt <= total;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            valid_out <= 1'b1;
            data_out  <= res[2*DATA_WD-1 -: DATA_WD];
            keep_out  <= top_keep(rcnt);
            last_out  <= 1'b1;
            res       <= '0;
            rcnt      <= '0;
            state     <= IDLE;
          end
        end
        DROP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
